// File: rtl/expr_result_unpacker_if.sv
// Handshake bundle between a packed-result producer and the field unpacker.
// The master drives the packed vector and consumes the unpacked beats.
interface expr_result_unpacker_if #(
  parameter int unsigned GROUPS = 3,
  parameter int unsigned IDX_W  = 5
);
  localparam int unsigned VW = 30 * GROUPS;

  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_y;
  logic          out_valid;
  logic          out_ready;
  logic [5:0]    out_data;
  logic [IDX_W-1:0] out_idx;
  logic          out_last;
  logic [5:0]    checksum;
  logic          done;

  modport master (
    output in_valid, in_y, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, checksum, done
  );

  modport slave (
    input  in_valid, in_y, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, checksum, done
  );
endinterface

// File: rtl/expr_result_unpacker.sv
// Captures one packed expression result vector and emits its fields one per beat,
// each extended to 6 bits (positions 0-2 unsigned, 3-5 signed within every
// 4/5/6/4/5/6-bit group), while accumulating a mod-64 checksum of emitted data.
module expr_result_unpacker #(
  parameter int unsigned GROUPS = 3,
  parameter int unsigned IDX_W  = 5
) (
  input logic clk,
  input logic rst_n,
  expr_result_unpacker_if.slave bus
);
  localparam int unsigned VW = 30 * GROUPS;
  localparam int unsigned NF = 6 * GROUPS;

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e           state_q, state_d;
  logic [VW-1:0]    sr_q, sr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       pos_q, pos_d;    // out_idx mod 6, kept as its own counter
  logic [5:0]       cks_q, cks_d;
  logic             done_q, done_d;

  logic [5:0] field;
  logic [2:0] width;
  logic       last;
  logic       accept;
  logic       in_ready;
  logic       capture;

  // Decode the field sitting in the top bits of the shift register
  always_comb begin
    field = sr_q[VW-1 -: 6];
    width = 3'd6;
    unique case (pos_q)
      3'd0: begin field = {2'b00, sr_q[VW-1 -: 4]};           width = 3'd4; end
      3'd1: begin field = {1'b0, sr_q[VW-1 -: 5]};            width = 3'd5; end
      3'd2: begin field = sr_q[VW-1 -: 6];                    width = 3'd6; end
      3'd3: begin field = {{2{sr_q[VW-1]}}, sr_q[VW-1 -: 4]}; width = 3'd4; end
      3'd4: begin field = {sr_q[VW-1], sr_q[VW-1 -: 5]};      width = 3'd5; end
      default: begin field = sr_q[VW-1 -: 6];                 width = 3'd6; end
    endcase
  end

  assign last     = (state_q == StEmit) && (idx_q == IDX_W'(NF - 1));
  assign accept   = (state_q == StEmit) && bus.out_ready;
  // Ready on the final accepted beat as well, so vectors stream with no bubble
  assign in_ready = (state_q == StIdle) || (last && bus.out_ready);
  assign capture  = bus.in_valid && in_ready;

  // Next-state: capture, beat acceptance and end-of-vector handling
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    pos_d   = pos_q;
    cks_d   = cks_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (capture) begin
          sr_d    = bus.in_y;
          idx_d   = '0;
          pos_d   = '0;
          cks_d   = '0;
          state_d = StEmit;
        end
      end
      default: begin
        if (accept) begin
          cks_d = cks_q + field;
          sr_d  = sr_q << width;
          idx_d = idx_q + IDX_W'(1);
          pos_d = (pos_q == 3'd5) ? 3'd0 : pos_q + 3'd1;
          if (last) begin
            done_d = 1'b1;
            idx_d  = '0;
            pos_d  = '0;
            if (capture) begin
              sr_d  = bus.in_y;
              cks_d = '0;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
    endcase
  end

  // State register with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sr_q    <= '0;
      idx_q   <= '0;
      pos_q   <= '0;
      cks_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      pos_q   <= pos_d;
      cks_q   <= cks_d;
      done_q  <= done_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == StEmit);
  assign bus.out_data  = field;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = last;
  assign bus.checksum  = cks_q;
  assign bus.done      = done_q;
endmodule
